// File: rtl/jtag_cmd_sched_pkg.sv
// Shared opcodes, FSM state encoding and STATUS word layout for the JTAG command sequencer.
package jtag_cmd_sched_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_HALT    = 8'h01;
  localparam logic [7:0] OP_RUN     = 8'h02;
  localparam logic [7:0] OP_STEP    = 8'h03;
  localparam logic [7:0] OP_SETADDR = 8'h04;
  localparam logic [7:0] OP_WRMEM   = 8'h05;
  localparam logic [7:0] OP_RDMEM   = 8'h06;
  localparam logic [7:0] OP_STATUS  = 8'h07;
  localparam logic [7:0] OP_CLRSTAT = 8'h08;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_WRITEBACK
  } state_e;

  localparam int unsigned STAT_HALTED = 0;
  localparam int unsigned STAT_TMO    = 1;
  localparam int unsigned STAT_ERR    = 2;
  localparam int unsigned STAT_OVR    = 3;

  localparam logic [15:0] TMO_DATA = 16'hDEAD;

endpackage

// File: rtl/jtag_cmd_sched_if.sv
// Memory request/acknowledge bus between the command sequencer (master) and the MCU memory (slave).
interface jtag_cmd_sched_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              memReq;
  logic              memWr;
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memWData;
  logic              memAck;
  logic [15:0]       memRData;

  modport master (
    output memReq, memWr, memAddr, memWData,
    input  memAck, memRData
  );

  modport slave (
    input  memReq, memWr, memAddr, memWData,
    output memAck, memRData
  );
endinterface

// File: rtl/jtag_cmd_sched_edge.sv
// Registered rising-edge detector for the JTAG update-state level.
module jtag_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/jtag_cmd_sched.sv
// JTAG command sequencer: decodes update-strobed instructions into core control and memory accesses.
// Optional memory-ack timeout is enabled by defining JTAG_SCHED_TIMEOUT_EN.
module jtag_cmd_sched
  import jtag_cmd_sched_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    jtagUpdate,
  input  logic [7:0]              jtagInstr,
  input  logic [15:0]             jtagDataIn,
  output logic                    jtagWrData,
  output logic [15:0]             jtagDataOut,
  jtag_cmd_sched_if.master        mem,
  output logic                    coreHalt,
  output logic                    coreStep,
  input  logic                    coreHalted,
  output logic                    busy
);

  state_e            state_q, state_d;
  logic [7:0]        instr_q, instr_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       result_q, result_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              halt_q, halt_d;
  logic              step_q, step_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;
  logic              rise, err_set, ovr_set, clr_stat;
  logic              tmo_hit, tmo;
  logic [15:0]       status;

  jtag_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (jtagUpdate),
    .rise_o (rise)
  );

  assign clr_stat = (state_q == ST_DECODE) && (instr_q == OP_CLRSTAT);

`ifdef JTAG_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;

  // The counter holds the number of MEM_WAIT cycles already spent without ack.
  assign tmo_hit = (state_q == ST_MEM_WAIT) && !mem.memAck && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign tmo     = tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ST_MEM_WAIT) ? cnt_q + 1'b1 : '0;
      if (tmo_hit)       tmo_q <= 1'b1;
      else if (clr_stat) tmo_q <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (rise) state_d = ST_DECODE;
      ST_DECODE: begin
        if (instr_q == OP_WRMEM || instr_q == OP_RDMEM) state_d = ST_MEM_REQ;
        else if (instr_q == OP_STATUS)                  state_d = ST_WRITEBACK;
        else                                            state_d = ST_IDLE;
      end
      ST_MEM_REQ:   state_d = ST_MEM_WAIT;
      ST_MEM_WAIT:
        if (mem.memAck || tmo_hit) state_d = (instr_q == OP_WRMEM) ? ST_IDLE : ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // memReq is a pure state decode so an async reset drops it without waiting for a clock.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    mem.memReq = (state_q == ST_MEM_WAIT);
    mem.memWr  = (state_q == ST_MEM_WAIT) && (instr_q == OP_WRMEM);
    jtagWrData = (state_q == ST_WRITEBACK);
  end

  always_comb begin
    status              = '0;
    status[STAT_HALTED] = coreHalted;
    status[STAT_TMO]    = tmo;
    status[STAT_ERR]    = err_q;
    status[STAT_OVR]    = ovr_q;
  end

  always_comb begin
    instr_d  = instr_q;
    data_d   = data_q;
    result_d = result_q;
    addr_d   = addr_q;
    halt_d   = halt_q;
    step_d   = 1'b0;
    err_set  = 1'b0;
    ovr_set  = rise && (state_q != ST_IDLE);
    if (state_q == ST_IDLE && rise) begin
      instr_d = jtagInstr;
      data_d  = jtagDataIn;
    end
    if (state_q == ST_DECODE) begin
      case (instr_q)
        OP_HALT:    halt_d = 1'b1;
        OP_RUN:     halt_d = 1'b0;
        OP_STEP:    if (halt_q) step_d = 1'b1; else err_set = 1'b1;
        OP_SETADDR: addr_d = ADDR_W'(data_q);
        OP_STATUS:  result_d = status;
        OP_NOP, OP_WRMEM, OP_RDMEM, OP_CLRSTAT: ;
        default:    err_set = 1'b1;
      endcase
    end
    if (state_q == ST_MEM_WAIT) begin
      if (mem.memAck) begin
        addr_d = addr_q + 1'b1;
        if (instr_q == OP_RDMEM) result_d = mem.memRData;
      end else if (tmo_hit && instr_q == OP_RDMEM) begin
        result_d = TMO_DATA;
      end
    end
    err_d = err_set | (err_q & ~clr_stat);
    ovr_d = ovr_set | (ovr_q & ~clr_stat);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '0;
      data_q   <= '0;
      result_q <= '0;
      addr_q   <= '0;
      halt_q   <= 1'b1;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      data_q   <= data_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      halt_q   <= halt_d;
      step_q   <= step_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  assign mem.memAddr  = addr_q;
  assign mem.memWData = data_q;
  assign jtagDataOut  = result_q;
  assign coreHalt     = halt_q;
  assign coreStep     = step_q;

endmodule

// File: doc/jtag_cmd_sched.md
Name: jtag_cmd_sched

Overview:
- Command sequencer between the JTAG port and the MCU.
- Edge-detects the port's update strobe and decodes the latched 8-bit instruction. Executes it against the core-control lines and a 16-bit memory bus with a req/ack handshake.
- Read results go back into the port's data register through its write-enable.
- Sits in the MCU top level, clocked by the system clock.

Parameters:
- ADDR_W, 16, width of memory address/auto-increment register.
- TIMEOUT, 255, cycles to wait for memAck before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- jtagUpdate  in  1  port update-state level; a command is issued on its rising edge.
- jtagInstr  in  8  latched instruction from the port.
- jtagDataIn  in  16  port data register contents.
- jtagWrData  out  1  one-cycle load strobe into the port data register.
- jtagDataOut  out  16  value loaded when jtagWrData=1.
- memReq  out  1  memory request.
- memWr  out  1  1=write, 0=read; valid with memReq.
- memAddr  out  ADDR_W  memory address.
- memWData  out  16  write data.
- memAck  in  1  one-cycle completion pulse.
- memRData  in  16  read data, valid with memAck.
- coreHalt  out  1  holds the core halted.
- coreStep  out  1  one-cycle single-step pulse.
- coreHalted  in  1  core status.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0 except coreHalt=1 (core halted out of reset). addr=0, status bits=0, state=IDLE.
- Start: a rising edge on jtagUpdate (registered previous value) in IDLE latches jtagInstr/jtagDataIn and goes to DECODE the next cycle.
- Overrun: a rising edge while busy drops the command and sets the sticky OVR bit.
- Opcodes, decoded in DECODE:
  - 0x00 NOP: back to IDLE.
  - 0x01 HALT: coreHalt<=1.
  - 0x02 RUN: coreHalt<=0.
  - 0x03 STEP: legal only if coreHalt=1; pulse coreStep for 1 cycle. If coreHalt=0, set ERR instead.
  - 0x04 SETADDR: addr<=jtagDataIn[ADDR_W-1:0].
  - 0x05 WRMEM: MEM_REQ with memWr=1, memWData=jtagDataIn.
  - 0x06 RDMEM: MEM_REQ with memWr=0.
  - 0x07 STATUS: WRITEBACK with {12'b0, OVR, ERR, TMO, coreHalted}.
  - 0x08 CLRSTAT: clear OVR/ERR/TMO.
  - Any other opcode: set ERR.
  - Every opcode except 0x05–0x07 returns to IDLE from DECODE.
- MEM_REQ/MEM_WAIT:
  - memReq, memWr, memAddr and memWData are held stable until the cycle memAck is seen; memReq drops the next cycle.
  - memAck in the same cycle memReq first rises is legal.
  - After ack, addr<=addr+1, wrapping 2^ADDR_W-1 -> 0.
  - Write: IDLE. Read: capture memRData, then WRITEBACK.
- WRITEBACK: jtagWrData=1 for exactly one cycle with jtagDataOut=result, then IDLE.
- Latency:
  - Edge to DECODE: 1 cycle.
  - Non-memory commands: complete at end of DECODE.
  - RDMEM with immediate ack: jtagWrData 3 cycles after DECODE.
- Concurrency: ERR/OVR set and CLRSTAT in the same cycle: set wins.
- Reset mid-transaction: memReq drops immediately (async) and the in-flight request is abandoned.

Optional Feature:
- Macro: JTAG_SCHED_TIMEOUT_EN.
- Enabled:
  - An 8+ bit counter runs in MEM_WAIT.
  - Reaching TIMEOUT without memAck drops memReq, sets sticky TMO and leaves addr unchanged.
  - A read writes back 16'hDEAD; a write goes to IDLE.
- Disabled: MEM_WAIT waits indefinitely, no counter exists, and the TMO status bit reads 0.

Decomposition:
- Shared package holds:
  - the opcode constants (OP_NOP … OP_CLRSTAT);
  - the state encoding (IDLE, DECODE, MEM_REQ, MEM_WAIT, WRITEBACK);
  - the STATUS bit indices;
  - the timeout readback constant 16'hDEAD.
- One natural sub-module: jtag_edge_det (registered rising-edge detector on jtagUpdate, async reset).

Test Plan:
- Reset, then STATUS: jtagWrData pulses once with jtagDataOut=16'h0001 (coreHalted tied 1).
- SETADDR 0x0010, then WRMEM 0xBEEF with ack after 3 cycles, then RDMEM returning 0x1234:
  - memAddr=0x0010 on the write; memWData held stable until ack;
  - memAddr=0x0011 on the read; jtagDataOut=0x1234.
- SETADDR 0xFFFF then WRMEM with ack: next RDMEM issues memAddr=0x0000 (wrap).
- RUN then STEP: coreHalt=0, no coreStep, STATUS shows ERR=1. HALT then STEP: exactly one coreStep pulse.
- Second jtagUpdate edge during MEM_WAIT:
  - the command is ignored and OVR=1;
  - CLRSTAT then STATUS returns 16'h0001.
- With JTAG_SCHED_TIMEOUT_EN and memAck never asserted:
  - RDMEM gives memReq low after TIMEOUT cycles, jtagDataOut=16'hDEAD and TMO=1;
  - rst asserted mid-wait drops memReq asynchronously.
